// File: rtl/elevator_pkg.sv
// elevator_pkg: shared floor/state types and default timing for the four-floor elevator.
package elevator_pkg;
    localparam int N_FLOORS = 4;
    localparam int FLOOR_W = 2;
    localparam int MOVE_CY_DEF = 50;
    localparam int DOOR_CY_DEF = 100;
    localparam int TIMER_W = 16;
    typedef logic [FLOOR_W-1:0] floor_t;
    typedef logic [N_FLOORS-1:0] fmask_t;
    typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, DOOR = 2'd2} state_t;
endpackage

// File: rtl/elevator_if.sv
// elevator_if: call inputs and car status outputs of the elevator scheduler.
interface elevator_if;
    import elevator_pkg::*;
    fmask_t hall_req;
    fmask_t cab_req;
    floor_t floor;
    logic door_open;
    logic moving;
    logic dir_up;
    fmask_t pending;
    logic arrive;
    modport master (
        output hall_req, cab_req,
        input floor, door_open, moving, dir_up, pending, arrive
    );
    modport slave (
        input hall_req, cab_req,
        output floor, door_open, moving, dir_up, pending, arrive
    );
endinterface

// File: rtl/elevator_timer.sv
// elevator_timer: loadable up-counter; done is high on the last cycle of a tc-cycle interval.
module elevator_timer
    import elevator_pkg::*;
(
    input logic clk,
    input logic rst,
    input logic load,
    input logic [TIMER_W-1:0] tc,
    output logic done
);
    logic [TIMER_W-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else cnt <= load ? '0 : cnt + 1'b1;
    end
    assign done = cnt == tc - 1'b1;
endmodule

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: four-floor car controller with latched calls and collective SCAN direction.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int MOVE_CY = MOVE_CY_DEF,
    parameter int DOOR_CY = DOOR_CY_DEF
) (
    input logic CLOCK_50,
    input logic RESET,
    elevator_if.slave bus
);
    state_t state, next;
    floor_t floor, nf;
    fmask_t pending, req, here, clr;
    logic dir_up, scan_dir, above, below, door_hit, done, load, arrive, moving, door_open;
    logic [TIMER_W-1:0] tc;

    assign req = bus.hall_req | bus.cab_req;
    assign here = fmask_t'(1) << floor;
    assign nf = dir_up ? (floor == floor_t'(N_FLOORS - 1) ? floor : floor + 1'b1)
                       : (floor == '0 ? floor : floor - 1'b1);
    assign door_hit = state == DOOR && |(req & here);
    assign above = |(pending >> ({1'b0, floor} + 3'd1));
    assign below = |(pending & (here - 1'b1));
    // Keep heading while work remains ahead, else turn; the end floors force the only legal way.
    assign scan_dir = floor == floor_t'(N_FLOORS - 1) ? 1'b0 :
                      floor == '0 ? 1'b1 :
                      dir_up ? (above | ~below) : (above & ~below);

    elevator_timer u_timer (
        .clk(CLOCK_50),
        .rst(RESET),
        .load(load),
        .tc(tc),
        .done(done)
    );

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            floor <= '0;
            dir_up <= 1'b1;
            pending <= '0;
            arrive <= 1'b0;
        end else begin
            state <= next;
            floor <= state == MOVE && done ? nf : floor;
            dir_up <= state != MOVE && next != state ? scan_dir : dir_up;
            pending <= (pending | (req & ~(door_open ? here : '0))) & ~clr;
            arrive <= next == DOOR && state != DOOR;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: next = ~|pending ? IDLE : |(pending & here) ? DOOR : MOVE;
            MOVE: next = done && pending[nf] ? DOOR : MOVE;
            DOOR: next = door_hit || !done ? DOOR : |pending ? MOVE : IDLE;
            default: next = IDLE;
        endcase
    end

    // A call at the open door only re-arms the door timer; it never becomes pending.
    always_comb begin
        moving = state == MOVE;
        door_open = state == DOOR;
        load = next != state || (state == MOVE && done) || door_hit;
        tc = state == DOOR ? TIMER_W'(DOOR_CY) : TIMER_W'(MOVE_CY);
        clr = next == DOOR && state != DOOR ? fmask_t'(1) << (state == MOVE ? nf : floor) : '0;
    end

    assign bus.floor = floor;
    assign bus.door_open = door_open;
    assign bus.moving = moving;
    assign bus.dir_up = dir_up;
    assign bus.pending = pending;
    assign bus.arrive = arrive;
endmodule

// File: doc/elevator_scheduler.md
ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 Parameter MOVE_CY, default 50, SHALL set the clock cycles spent travelling one floor.
REQ-002 Parameter DOOR_CY, default 100, SHALL set the clock cycles the door stays open per stop.
REQ-003 CLOCK_50  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  SHALL be the reset: asynchronous, active-high; the top level drives it from SW[17].
REQ-005 hall_req  input  4  SHALL carry external calls, active-high, bit i = floor i+1; already synchronised.
REQ-006 cab_req  input  4  SHALL carry cabin calls, active-high, bit i = floor i+1; the top level inverts active-low KEY.
REQ-007 floor  output  2  SHALL give the current floor, 0..3 = floors 1..4.
REQ-008 door_open  output  1  SHALL be high while the door is open.
REQ-009 moving  output  1  SHALL be high while travelling.
REQ-010 dir_up  output  1  SHALL give the travel direction: 1 = up, 0 = down.
REQ-011 pending  output  4  SHALL show the latched, unserved requests.
REQ-012 arrive  output  1  SHALL pulse high for one cycle on the edge door_open rises.

Function
REQ-013 The pending bit i SHALL set on any edge where hall_req[i] or cab_req[i] is high; it SHALL stay set until served.
REQ-014 The FSM SHALL have exactly three states: IDLE, MOVE and DOOR.
REQ-015 IDLE, pending empty: the FSM SHALL remain in IDLE with all motion outputs low.
REQ-016 IDLE, pending[floor] set: the FSM SHALL enter DOOR on the next edge and clear that bit on the same edge.
REQ-017 IDLE, pending set only at other floors: the FSM SHALL enter MOVE on the next edge with dir_up chosen by REQ-021.
REQ-018 In MOVE, floor SHALL step by ±1 exactly MOVE_CY cycles after MOVE entry or after the previous step.
REQ-019 After each step in MOVE:
- If pending[new floor] is set, the FSM SHALL enter DOOR on the same edge and clear that bit.
- Otherwise the FSM SHALL continue in MOVE.
REQ-020 DOOR SHALL last exactly DOOR_CY cycles, then:
- Go to MOVE if pending is non-empty.
- Otherwise go to IDLE.
REQ-021 Direction SHALL follow a collective SCAN policy:
- Keep dir_up while any request is pending in that direction.
- Otherwise reverse.
- With no pending requests, keep the last direction.
REQ-022 A request for the current floor during DOOR SHALL restart the DOOR_CY timer and SHALL NOT set pending.
REQ-023 A request for the current floor during MOVE, before the step, SHALL set pending and be served on a later pass.
REQ-024 floor SHALL never go below 0 or above 3; a step beyond the range SHALL NOT occur.
REQ-025 dir_up SHALL be forced to 0 at floor 3 and to 1 at floor 0 whenever the FSM leaves DOOR or IDLE.
REQ-026 Simultaneous hall_req and cab_req for the same floor SHALL set one pending bit; they need one service.
REQ-027 moving SHALL be high in MOVE only, and door_open SHALL be high in DOOR only; the two SHALL never be high together.

Reset
REQ-028 RESET high SHALL immediately set every state element to its reset value, regardless of the clock, including mid-move and mid-door:
- state = IDLE, floor = 0, dir_up = 1.
- pending = 0, moving = 0, door_open = 0, arrive = 0.
- Timer = 0.
REQ-029 Requests presented while RESET is high SHALL be ignored.
REQ-030 The first request SHALL be honoured on the first edge after RESET falls.

Structure
REQ-031 Package elevator_pkg SHALL hold:
- N_FLOORS = 4 and floor width 2.
- The IDLE, MOVE and DOOR state encodings.
- The default MOVE_CY and DOOR_CY values.
REQ-032 One sub-module, elevator_timer, SHALL provide a loadable cycle counter:
- Inputs: load, terminal count.
- Output: a done pulse.
- Used for both MOVE and DOOR timing.
REQ-033 The request register and the SCAN next-direction logic SHALL live in elevator_scheduler itself.

Verification
REQ-034 Reset, then hall_req=0100 for 1 cycle at edge k ->
- Edge k+1: moving high.
- Floor 1 at k+1+50, floor 2 at k+1+100; door_open and arrive at k+101.
- pending=0000; door closes at k+201.
REQ-035 At floor 2, idle, cab_req=1000 pulse -> one floor up in 50 cycles, then door 100 cycles, then IDLE with floor=3.
REQ-036 At floor 3, idle, cab_req=1000 -> DOOR next edge with no movement; then hall_req=0010 -> dir_up=0, door at floor 1 after 100 cycles of travel.
REQ-037 Moving up from 0 with pending=1000, hall_req=0010 injected before the floor-1 step -> stop at floor 1 (100-cycle door), continue to floor 3; no reversal.
REQ-038 RESET asserted mid-MOVE between floors 1 and 2 -> asynchronously floor=0, pending=0000, moving=0 before the next clock edge.
REQ-039 During DOOR at floor 2, cab_req=0100 at cycle 60 of 100 -> door stays open 100 more cycles; pending stays 0000.
